// File: rtl/hsv_pkg.sv
// rtl/hsv_pkg.sv - shared types and helpers for the RGB to HSV pipeline
package hsv_pkg;

  // Sector names list channels as max, mid, min.
  typedef enum logic [2:0] {
    SEC_RGB,
    SEC_RBG,
    SEC_GRB,
    SEC_GBR,
    SEC_BRG,
    SEC_BGR
  } sector_t;

  localparam int CH_B = 0;
  localparam int CH_G = 1;
  localparam int CH_R = 2;
  localparam int CH_V = 0;
  localparam int CH_S = 1;
  localparam int CH_H = 2;

  // Hue origin of the sextant pair owned by the max channel.
  function automatic int unsigned hue_base(input sector_t sec, input int unsigned depth);
    case (sec)
      SEC_RGB, SEC_RBG: hue_base = 0;
      SEC_GRB, SEC_GBR: hue_base = (32'd1 << depth) / 3;
      default:          hue_base = (32'd1 << (depth + 1)) / 3;
    endcase
  endfunction

  // Sectors where the hue fraction is subtracted from the base.
  function automatic logic hue_sub(input sector_t sec);
    hue_sub = (sec == SEC_RBG) || (sec == SEC_GRB) || (sec == SEC_BGR);
  endfunction

endpackage

// File: rtl/pipe_divider.sv
// rtl/pipe_divider.sv - restoring divider, one quotient bit per pipeline stage
module pipe_divider #(
  parameter int NW = 16,
  parameter int DW = 11,
  parameter int QW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          in_valid,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic [QW-1:0] quotient
);
  // Wide enough to compare the remainder against the divisor at any shift.
  localparam int WW = NW + DW + QW;

  logic [NW-1:0] rem_q  [QW-1];
  logic [DW-1:0] den_q  [QW-1];
  logic [QW-2:0] vld_q;
  logic [QW-1:0] quo_q  [QW];

  logic [NW-1:0] rem_in [QW];
  logic [DW-1:0] den_in [QW];
  logic [QW-1:0] quo_in [QW];
  logic [QW-1:0] vld_in;
  logic [WW-1:0] sub_w  [QW];
  logic [QW-1:0] take;
  logic [NW-1:0] rem_nx [QW];
  logic [QW-1:0] quo_nx [QW];

  // Stage inputs: port values for stage 0, previous stage registers after that.
  always_comb begin
    rem_in[0] = dividend;
    den_in[0] = divisor;
    quo_in[0] = '0;
    vld_in[0] = in_valid;
    for (int k = 1; k < QW; k++) begin
      rem_in[k] = rem_q[k-1];
      den_in[k] = den_q[k-1];
      quo_in[k] = quo_q[k-1];
      vld_in[k] = vld_q[k-1];
    end
  end

  // Stage k decides quotient bit QW-1-k; a zero divisor never sets a bit.
  always_comb begin
    for (int k = 0; k < QW; k++) begin
      sub_w[k]  = {{(WW-DW){1'b0}}, den_in[k]} << (QW - 1 - k);
      take[k]   = vld_in[k] && (den_in[k] != '0) &&
                  ({{(WW-NW){1'b0}}, rem_in[k]} >= sub_w[k]);
      rem_nx[k] = take[k] ? rem_in[k] - sub_w[k][NW-1:0] : rem_in[k];
      quo_nx[k] = quo_in[k];
      quo_nx[k][QW-1-k] = take[k];
    end
  end

  // Advance all stages together; bubbles carry zeros so nothing undefined flows out.
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q <= '0;
      for (int k = 0; k < QW - 1; k++) begin
        rem_q[k] <= '0;
        den_q[k] <= '0;
      end
      for (int k = 0; k < QW; k++) quo_q[k] <= '0;
    end else if (en) begin
      for (int k = 0; k < QW - 1; k++) begin
        rem_q[k] <= vld_in[k] ? rem_nx[k] : '0;
        den_q[k] <= vld_in[k] ? den_in[k] : '0;
        vld_q[k] <= vld_in[k];
      end
      for (int k = 0; k < QW; k++) quo_q[k] <= vld_in[k] ? quo_nx[k] : '0;
    end
  end

  assign quotient = quo_q[QW-1];

endmodule

// File: rtl/rgb2hsv_pipe.sv
// rtl/rgb2hsv_pipe.sv - pipelined RGB to HSV converter with hue rotation and sideband
module rgb2hsv_pipe
  import hsv_pkg::*;
#(
  parameter int RGB_DEPTH  = 8,
  parameter int HSV_DEPTH  = 8,
  parameter int USER_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [3*RGB_DEPTH-1:0] in_data,
  input  logic [USER_WIDTH-1:0]  in_user,
  input  logic [HSV_DEPTH-1:0]   hue_offset,
  output logic                   out_ready,
  output logic                   out_valid,
  output logic [3*HSV_DEPTH-1:0] out_data,
  output logic [USER_WIDTH-1:0]  out_user,
  input  logic                   in_ready
);
  localparam int LATENCY = HSV_DEPTH + 5;
  localparam int RW      = RGB_DEPTH;
  localparam int HW      = HSV_DEPTH;
  localparam int QW      = HW + 1;
  localparam int NW      = RW + HW;
  localparam int DWH     = RW + 3;
  localparam int SBW     = USER_WIDTH + 3 * HW + 2;

  logic [LATENCY-1:0] valid;
  logic               run;

  assign run       = in_ready | ~valid[LATENCY-1];
  assign out_ready = run;
  assign out_valid = valid[LATENCY-1];

  // Valid bits shift one slot per enabled cycle; bubbles are never collapsed.
  always_ff @(posedge clk) begin
    if (reset)    valid <= '0;
    else if (run) valid <= {valid[LATENCY-2:0], in_valid};
  end

  logic [RW-1:0] in_r, in_g, in_b;
  sector_t       sec_in;

  assign in_r = in_data[CH_R*RW +: RW];
  assign in_g = in_data[CH_G*RW +: RW];
  assign in_b = in_data[CH_B*RW +: RW];

  // Sector from the raw inputs; max ties resolve R over G over B.
  always_comb begin
    if (in_r >= in_g && in_r >= in_b) sec_in = (in_g >= in_b) ? SEC_RGB : SEC_RBG;
    else if (in_g >= in_b)            sec_in = (in_r >= in_b) ? SEC_GRB : SEC_GBR;
    else                              sec_in = (in_r >= in_g) ? SEC_BRG : SEC_BGR;
  end

  logic [RW-1:0]         r0, g0, b0, max1, mid1, min1, d2, e2, max2;
  sector_t               sec0, sec1;
  logic [HW-1:0]         off0, off1, off2, base2;
  logic [USER_WIDTH-1:0] user0, user1, user2;
  logic                  sub2;

  // Stage 0: capture pixel, sector, hue offset and sideband together.
  always_ff @(posedge clk) begin
    if (reset) begin
      r0 <= '0; g0 <= '0; b0 <= '0; sec0 <= SEC_RGB; off0 <= '0; user0 <= '0;
    end else if (run) begin
      r0 <= in_r; g0 <= in_g; b0 <= in_b; sec0 <= sec_in; off0 <= hue_offset; user0 <= in_user;
    end
  end

  // Stage 1: order channels as max, mid, min.
  always_ff @(posedge clk) begin
    if (reset) begin
      max1 <= '0; mid1 <= '0; min1 <= '0; sec1 <= SEC_RGB; off1 <= '0; user1 <= '0;
    end else if (run) begin
      case (sec0)
        SEC_RGB: {max1, mid1, min1} <= {r0, g0, b0};
        SEC_RBG: {max1, mid1, min1} <= {r0, b0, g0};
        SEC_GRB: {max1, mid1, min1} <= {g0, r0, b0};
        SEC_GBR: {max1, mid1, min1} <= {g0, b0, r0};
        SEC_BRG: {max1, mid1, min1} <= {b0, r0, g0};
        default: {max1, mid1, min1} <= {b0, g0, r0};
      endcase
      sec1 <= sec0; off1 <= off0; user1 <= user0;
    end
  end

  // Stage 2: chroma span, hue numerator and the sector's base and direction.
  always_ff @(posedge clk) begin
    if (reset) begin
      d2 <= '0; e2 <= '0; max2 <= '0; base2 <= '0; sub2 <= 1'b0; off2 <= '0; user2 <= '0;
    end else if (run) begin
      d2    <= max1 - min1;
      e2    <= mid1 - min1;
      max2  <= max1;
      base2 <= HW'(hue_base(sec1, HW));
      sub2  <= hue_sub(sec1);
      off2  <= off1;
      user2 <= user1;
    end
  end

  logic [NW-1:0]  hue_num, sat_num;
  logic [DWH-1:0] hue_den;
  logic [HW-1:0]  v3;
  logic [SBW-1:0] sb3;
  logic [QW-1:0]  hue_q, sat_q;

  // Stage 3 operands feed the dividers directly; 6*d is built as 4d + 2d.
  assign hue_num = {e2, {HW{1'b0}}};
  assign sat_num = {d2, {HW{1'b0}}};
  assign hue_den = {1'b0, d2, 2'b00} + {2'b00, d2, 1'b0};

  if (RW >= HW) begin : g_v_trunc
    assign v3 = max2[RW-1 -: HW];
  end else begin : g_v_pad
    assign v3 = {max2, {(HW-RW){1'b0}}};
  end

  assign sb3 = {user2, off2, base2, sub2, (d2 == '0), v3};

  pipe_divider #(.NW(NW), .DW(DWH), .QW(QW)) u_hue_div (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .in_valid (valid[2]),
    .dividend (hue_num),
    .divisor  (hue_den),
    .quotient (hue_q)
  );

  pipe_divider #(.NW(NW), .DW(RW), .QW(QW)) u_sat_div (
    .clk      (clk),
    .reset    (reset),
    .en       (run),
    .in_valid (valid[2]),
    .dividend (sat_num),
    .divisor  (max2),
    .quotient (sat_q)
  );

  logic [SBW-1:0] sb_q [QW];

  // Everything the final stage needs besides the quotients rides beside the dividers.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < QW; k++) sb_q[k] <= '0;
    end else if (run) begin
      sb_q[0] <= sb3;
      for (int k = 1; k < QW; k++) sb_q[k] <= sb_q[k-1];
    end
  end

  logic [USER_WIDTH-1:0] user_f;
  logic [HW-1:0]         off_f, base_f, v_f, f_f, s_full, h_n, s_n;
  logic                  sub_f, dz_f;

  assign {user_f, off_f, base_f, sub_f, dz_f, v_f} = sb_q[QW-1];

  // A quotient of exactly 2^HW (full saturation) is clipped to the largest code.
  function automatic logic [HW-1:0] clip_q(input logic [QW-1:0] q);
    clip_q = q[HW] ? {HW{1'b1}} : q[HW-1:0];
  endfunction

  assign f_f    = clip_q(hue_q);
  assign s_full = clip_q(sat_q);

  // Compose hue with modular wrap; grey and black take the offset alone.
  always_comb begin
    h_n = off_f;
    s_n = '0;
    if (!dz_f) begin
      h_n = (sub_f ? base_f - f_f : base_f + f_f) + off_f;
      s_n = s_full;
    end
  end

  logic [HW-1:0]         h_q, s_q, v_q;
  logic [USER_WIDTH-1:0] user_q;

  // Output register only moves when the slot behind it holds a real pixel.
  always_ff @(posedge clk) begin
    if (reset) begin
      h_q <= '0; s_q <= '0; v_q <= '0; user_q <= '0;
    end else if (run && valid[LATENCY-2]) begin
      h_q <= h_n; s_q <= s_n; v_q <= v_f; user_q <= user_f;
    end
  end

  assign out_data[CH_H*HW +: HW] = h_q;
  assign out_data[CH_S*HW +: HW] = s_q;
  assign out_data[CH_V*HW +: HW] = v_q;
  assign out_user                = user_q;

endmodule

// File: tb/tb_rgb2hsv_pipe.sv
// tb/tb_rgb2hsv_pipe.sv - bench for rgb2hsv_pipe
module tb_rgb2hsv_pipe;
  localparam int RD  = 8;
  localparam int HD  = 8;
  localparam int UW  = 8;
  localparam int LAT = HD + 5;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready, out_ready, out_valid;
  logic [3*RD-1:0] in_data;
  logic [UW-1:0]   in_user, out_user;
  logic [HD-1:0]   hue_offset;
  logic [3*HD-1:0] out_data;

  always #5 clk = ~clk;

  rgb2hsv_pipe #(.RGB_DEPTH(RD), .HSV_DEPTH(HD), .USER_WIDTH(UW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_user    (in_user),
    .hue_offset (hue_offset),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_user   (out_user),
    .in_ready   (in_ready)
  );

  typedef struct {int r; int g; int b; int off; int user;} pix_t;
  typedef struct {int r; int g; int b; int off; int h; int s; int v;} vec_t;

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  pix_t src_q[$];
  pix_t acc_q[$];
  logic [3*HD+UW-1:0] got_q[$];
  int acc_cyc[$];
  int got_cyc[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // HSV from the colour-wheel definition using plain integer arithmetic.
  function automatic logic [3*HD-1:0] ref_hsv(input pix_t p);
    int mx, mn, d, e, base, sgn, h, s, q, full;
    full = 1 << HD;
    mx = (p.r > p.g) ? p.r : p.g;
    mx = (mx > p.b) ? mx : p.b;
    mn = (p.r < p.g) ? p.r : p.g;
    mn = (mn < p.b) ? mn : p.b;
    d = mx - mn;
    if (d == 0) begin
      h = p.off;
      s = 0;
    end else begin
      if (p.r >= p.g && p.r >= p.b) begin
        base = 0;
        if (p.g >= p.b) begin e = p.g - p.b; sgn = 1; end
        else begin e = p.b - p.g; sgn = -1; end
      end else if (p.g >= p.b) begin
        base = full / 3;
        if (p.b >= p.r) begin e = p.b - p.r; sgn = 1; end
        else begin e = p.r - p.b; sgn = -1; end
      end else begin
        base = (2 * full) / 3;
        if (p.r >= p.g) begin e = p.r - p.g; sgn = 1; end
        else begin e = p.g - p.r; sgn = -1; end
      end
      h = base + sgn * ((e * full) / (6 * d)) + p.off;
      h = ((h % full) + full) % full;
      q = (d * full) / mx;
      s = (q > full - 1) ? full - 1 : q;
    end
    return {HD'(h), HD'(s), HD'(mx)};
  endfunction

  // Drive src_q back-to-back, record acceptances and outputs, police hold and ready rules.
  task automatic stream(input int n, input bit rand_ready);
    int idx, guard;
    bit held, exp_rdy;
    logic [3*HD-1:0] hd;
    logic [UW-1:0] hu;
    idx = 0; guard = 0; held = 0; hd = '0; hu = '0;
    acc_q.delete(); got_q.delete(); acc_cyc.delete(); got_cyc.delete();
    while (got_q.size() < n && guard < 400) begin
      @(posedge clk); #1;
      if (idx < n) begin
        in_valid   = 1'b1;
        in_data    = {RD'(src_q[idx].r), RD'(src_q[idx].g), RD'(src_q[idx].b)};
        hue_offset = HD'(src_q[idx].off);
        in_user    = UW'(src_q[idx].user);
      end else begin
        in_valid   = 1'b0;
        in_data    = 24'($urandom);
        hue_offset = HD'($urandom);
        in_user    = UW'($urandom);
      end
      in_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      cyc++; guard++;
      if (held) begin
        check("hold_data", out_data, hd);
        check("hold_user", out_user, hu);
      end
      exp_rdy = in_ready || !out_valid;
      check("out_ready", out_ready, exp_rdy);
      if (in_valid && out_ready) begin
        acc_q.push_back(src_q[idx]);
        acc_cyc.push_back(cyc);
        idx++;
      end
      if (out_valid && in_ready) begin
        got_q.push_back({out_data, out_user});
        got_cyc.push_back(cyc);
      end
      held = out_valid && !in_ready;
      hd = out_data;
      hu = out_user;
    end
    check("stream_count", got_q.size(), n);
    in_valid = 1'b0;
    in_ready = 1'b1;
  endtask

  vec_t tbl[12];
  logic [3*HD+UW-1:0] g;
  pix_t p;
  int stale;

  initial begin
    reset = 1'b1; in_valid = 1'b0; in_ready = 1'b1;
    in_data = '0; in_user = '0; hue_offset = '0;

    tbl[0]  = '{255, 0, 0, 0, 0, 255, 255};
    tbl[1]  = '{0, 255, 0, 0, 85, 255, 255};
    tbl[2]  = '{0, 0, 255, 0, 170, 255, 255};
    tbl[3]  = '{255, 255, 0, 0, 42, 255, 255};
    tbl[4]  = '{255, 0, 255, 0, 214, 255, 255};
    tbl[5]  = '{128, 128, 128, 0, 0, 0, 128};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[7]  = '{255, 0, 0, 200, 200, 255, 255};
    tbl[8]  = '{0, 0, 255, 100, 14, 255, 255};
    tbl[9]  = '{0, 255, 255, 0, 127, 255, 255};
    tbl[10] = '{100, 50, 25, 0, 14, 192, 100};
    tbl[11] = '{7, 7, 7, 33, 33, 0, 7};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_user", out_user, 0);
    check("rst_out_ready", out_ready, 1);

    for (int i = 0; i < 12; i++) begin
      src_q.delete();
      src_q.push_back('{tbl[i].r, tbl[i].g, tbl[i].b, tbl[i].off, i + 1});
      stream(1, 1'b0);
      if (got_q.size() == 1) begin
        g = got_q[0];
        check($sformatf("vec%0d_x", i), 64'($isunknown(g)), 0);
        check($sformatf("vec%0d_h", i), g[31:24], tbl[i].h);
        check($sformatf("vec%0d_s", i), g[23:16], tbl[i].s);
        check($sformatf("vec%0d_v", i), g[15:8], tbl[i].v);
        check($sformatf("vec%0d_user", i), g[7:0], i + 1);
        check($sformatf("vec%0d_lat", i), got_cyc[0] - acc_cyc[0], LAT);
      end
    end

    // Two rotated pixels back-to-back; offset keeps changing while they fly.
    src_q.delete();
    src_q.push_back('{255, 0, 0, 200, 33});
    src_q.push_back('{0, 0, 255, 100, 34});
    stream(2, 1'b0);
    if (got_q.size() == 2) begin
      g = got_q[0];
      check("pair0_h", g[31:24], 200);
      check("pair0_user", g[7:0], 33);
      check("pair0_lat", got_cyc[0] - acc_cyc[0], LAT);
      g = got_q[1];
      check("pair1_h", g[31:24], 14);
      check("pair1_user", g[7:0], 34);
      check("pair1_lat", got_cyc[1] - acc_cyc[1], LAT);
    end

    // Random burst with random downstream backpressure.
    src_q.delete();
    for (int i = 0; i < 20; i++)
      src_q.push_back('{$urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
                        $urandom_range(0, 255), 100 + i});
    stream(20, 1'b1);
    for (int i = 0; i < got_q.size(); i++) begin
      g = got_q[i];
      check($sformatf("rand%0d_hsv", i), g[31:8], ref_hsv(acc_q[i]));
      check($sformatf("rand%0d_user", i), g[7:0], 100 + i);
    end

    // Reset with ten pixels in flight.
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_ready = 1'b1;
      in_data = 24'($urandom) | 24'h800000;
      in_user = UW'(i);
      hue_offset = HD'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_user", out_user, 0);
    stale = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("stale_pixels", stale, 0);

    p = '{40, 200, 90, 17, 77};
    src_q.delete();
    src_q.push_back(p);
    stream(1, 1'b0);
    if (got_q.size() == 1) begin
      g = got_q[0];
      check("post_rst_hsv", g[31:8], ref_hsv(p));
      check("post_rst_user", g[7:0], 77);
      check("post_rst_lat", got_cyc[0] - acc_cyc[0], LAT);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
